uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter DIV_W, default 9, meaning the width of cfg_clk_div.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1, the reset; it is synchronous and active-high.
REQ-004 SHALL have port cfg_clk_div, input, DIV_W, where bit period = cfg_clk_div+1 clk cycles.
REQ-005 SHALL have port cfg_has_parity, input, 1, which inserts a parity bit after the data bits.
REQ-006 SHALL have port cfg_odd_parity, input, 1, where 1 = odd parity and 0 = even parity.
REQ-007 SHALL have port cfg_extend_stop, input, 1, where 1 = two stop bits and 0 = one.
REQ-008 SHALL have port cfg_lsb_first, input, 1, where 1 = LSB sent first and 0 = MSB first.
REQ-009 SHALL have port cfg_word, input, 2, where 00/01/10/11 = 5/6/7/8 data bits.
REQ-010 SHALL have port tx_data, input, 8, the word to send; only bits [n-1:0] are used, n = word length.
REQ-011 SHALL have port tx_valid, input, 1, which requests transmission of tx_data.
REQ-012 SHALL have port tx_ready, output, 1, which is high when a word can be accepted.
REQ-013 SHALL have port uart_tx_busy, output, 1, which is high while a frame is on the line.
REQ-014 SHALL have port uart_tx_done_it, output, 1, a one-cycle pulse at frame completion.
REQ-015 SHALL have port ms_utx, output, 1, the serial line; it is high when idle.

Function
REQ-016 SHALL implement the FSM states IDLE, START, DATA, PARITY and STOP.
REQ-017 SHALL accept a word on any rising edge where tx_valid=1 and tx_ready=1; tx_ready=1 only in IDLE.
REQ-018 SHALL, on acceptance, latch tx_data and all cfg_* inputs; cfg_* changes mid-frame SHALL NOT affect the current frame.
REQ-019 SHALL go from IDLE to START on acceptance, so ms_utx drives 0 in the cycle following the accept edge (latency 1).
REQ-020 SHALL hold each bit for exactly cfg_clk_div+1 cycles using a down-counter reloaded at each bit boundary; cfg_clk_div=0 gives 1 cycle per bit.
REQ-021 SHALL go START -> DATA after one bit period.
REQ-022 SHALL, in DATA, send n bits: bit 0 upward if lsb_first, otherwise bit n-1 downward.
REQ-023 SHALL, after the last data bit, go to PARITY if has_parity, else to STOP.
REQ-024 SHALL set the parity bit to the XOR of the n transmitted bits, inverted when odd_parity; bits above n-1 are excluded.
REQ-025 SHALL drive ms_utx=1 in STOP for 1 bit period, or 2 if extend_stop, then return to IDLE.
REQ-026 SHALL assert uart_tx_done_it for exactly the first IDLE cycle after STOP; tx_ready is 1 in that same cycle.
REQ-027 SHALL start a frame accepted in the done cycle on the next cycle, giving exactly 1 idle-high cycle between frames.
REQ-028 SHALL hold uart_tx_busy=1 in START, DATA, PARITY and STOP, and 0 in IDLE.
REQ-029 SHALL register ms_utx with no combinational path from any input to ms_utx.
REQ-030 SHALL produce frame length in cycles = (cfg_clk_div+1) x (1 + n + has_parity + 1 + extend_stop).
REQ-031 SHALL ignore tx_valid while busy; the word is neither queued nor lost-flagged.

Reset
REQ-032 SHALL, while rst=1 at a rising edge, force state=IDLE, ms_utx=1, tx_ready=1, uart_tx_busy=0, uart_tx_done_it=0, clear the bit counter and clear the divider counter.
REQ-033 SHALL, when rst is asserted mid-frame, abort the frame, drive ms_utx=1 on the next cycle, and produce no done pulse.
REQ-034 SHALL NOT accept tx_valid in any cycle where rst=1.

Verification
REQ-035 SHALL cover: div=4, 8N1, LSB-first, 0xCA -> ms_utx = 0,0,1,0,1,0,0,1,1,1, each held 5 cycles; 50-cycle frame; done pulse in cycle 51.
REQ-036 SHALL cover: div=4, 8 bits, MSB-first, even parity, 0x53 -> 0,0,1,0,1,0,0,1,1, parity 0, stop 1; 55-cycle frame.
REQ-037 SHALL cover: div=1, 7 bits, MSB-first, odd parity, 0x41 -> 0,1,0,0,0,0,0,1, parity 1, stop 1; bit 7 ignored; 20-cycle frame.
REQ-038 SHALL cover: div=0, 5 bits, extend_stop=1, 0xF8 sent back-to-back with 0x80 (tx_valid held) -> 0,0,0,0,1,1,1,1 then one idle 1, then 0,0,0,0,0,0,1,1.
REQ-039 SHALL cover: rst pulsed in DATA of a div=4 frame -> ms_utx=1 and tx_ready=1 the next cycle, no done pulse, and the next frame correct.
REQ-040 SHALL cover: cfg_lsb_first and cfg_word toggled mid-frame -> the current frame is unchanged and the next frame uses the new config.

Source files
------------

// File: rtl/uart_tx.sv
// uart_tx: configurable UART transmitter. It sends one frame per accepted
// word: a start bit, 5 to 8 data bits, an optional parity bit and one or
// two stop bits.
//
// Ports:
//   clk, rst        - rising-edge clock; synchronous active-high reset
//   cfg_clk_div     - bit period is cfg_clk_div+1 clk cycles
//   cfg_has_parity  - insert a parity bit after the data bits
//   cfg_odd_parity  - 1 = odd parity, 0 = even parity
//   cfg_extend_stop - 1 = two stop bits, 0 = one stop bit
//   cfg_lsb_first   - 1 = LSB first, 0 = MSB first
//   cfg_word        - 00/01/10/11 = 5/6/7/8 data bits
//   tx_data         - word to send; only the low n bits are used
//   tx_valid        - transmit request; taken only when tx_ready is high
//   tx_ready        - high in IDLE, when a word can be accepted
//   uart_tx_busy    - high while a frame is on the line
//   uart_tx_done_it - one-cycle pulse in the first IDLE cycle after a frame
//   ms_utx          - registered serial line, high when idle
module uart_tx #(
    parameter int unsigned DIV_W = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] cfg_clk_div,
    input  logic             cfg_has_parity,
    input  logic             cfg_odd_parity,
    input  logic             cfg_extend_stop,
    input  logic             cfg_lsb_first,
    input  logic [1:0]       cfg_word,
    input  logic [7:0]       tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             uart_tx_busy,
    output logic             uart_tx_done_it,
    output logic             ms_utx
);

    localparam int unsigned BIT_W  = 3;
    localparam int unsigned DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   cnt_q, cnt_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic               par_en_q, par_en_d;
    logic               odd_q, odd_d;
    logic               ext_q, ext_d;
    logic               lsb_q, lsb_d;
    logic [1:0]         word_q, word_d;
    logic               line_d;
    logic               done_d;

    logic               bit_end;
    logic [BIT_W-1:0]   last_idx;
    logic [DATA_W-1:0]  word_mask;
    logic               par_bit;
    logic [BIT_W-1:0]   sel_idx;

    // End of the current bit period; the counter is reloaded at each boundary.
    assign bit_end   = (cnt_q == '0);
    // Index of the highest data bit: 4..7 for 5..8 data bits.
    assign last_idx  = BIT_W'(3'd4 + BIT_W'(word_q));
    // Excludes data bits above the configured word length from parity.
    assign word_mask = DATA_W'(8'hFF >> (2'd3 - word_q));
    assign par_bit   = (^(data_q & word_mask)) ^ odd_q;

    // Next-state, counters, latched frame config and next line level.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        data_d   = data_q;
        div_d    = div_q;
        par_en_d = par_en_q;
        odd_d    = odd_q;
        ext_d    = ext_q;
        lsb_d    = lsb_q;
        word_d   = word_q;
        done_d   = 1'b0;
        line_d   = 1'b1;
        sel_idx  = '0;

        case (state_q)
            IDLE: begin
                if (tx_valid) begin
                    state_d  = START;
                    cnt_d    = cfg_clk_div;
                    bit_d    = '0;
                    data_d   = tx_data;
                    div_d    = cfg_clk_div;
                    par_en_d = cfg_has_parity;
                    odd_d    = cfg_odd_parity;
                    ext_d    = cfg_extend_stop;
                    lsb_d    = cfg_lsb_first;
                    word_d   = cfg_word;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    cnt_d   = div_q;
                    bit_d   = '0;
                end else begin
                    cnt_d = cnt_q - DIV_W'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d = div_q;
                    if (bit_q == last_idx) begin
                        state_d = par_en_q ? PARITY : STOP;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q - DIV_W'(1);
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    cnt_d   = div_q;
                    bit_d   = '0;
                end else begin
                    cnt_d = cnt_q - DIV_W'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    // bit_q counts stop bits already sent.
                    if (ext_q && (bit_q == '0)) begin
                        cnt_d = div_q;
                        bit_d = BIT_W'(1);
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        bit_d   = '0;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - DIV_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                bit_d   = '0;
            end
        endcase

        // Line level for the cycle after this edge, from the latched frame config.
        sel_idx = lsb_q ? bit_d : BIT_W'(last_idx - bit_d);
        case (state_d)
            START:   line_d = 1'b0;
            DATA:    line_d = data_q[sel_idx];
            PARITY:  line_d = par_bit;
            default: line_d = 1'b1;
        endcase
    end

    // State, counters, latched config and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            bit_q           <= '0;
            data_q          <= '0;
            div_q           <= '0;
            par_en_q        <= 1'b0;
            odd_q           <= 1'b0;
            ext_q           <= 1'b0;
            lsb_q           <= 1'b0;
            word_q          <= '0;
            ms_utx          <= 1'b1;
            tx_ready        <= 1'b1;
            uart_tx_busy    <= 1'b0;
            uart_tx_done_it <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            bit_q           <= bit_d;
            data_q          <= data_d;
            div_q           <= div_d;
            par_en_q        <= par_en_d;
            odd_q           <= odd_d;
            ext_q           <= ext_d;
            lsb_q           <= lsb_d;
            word_q          <= word_d;
            ms_utx          <= line_d;
            tx_ready        <= (state_d == IDLE);
            uart_tx_busy    <= (state_d != IDLE);
            uart_tx_done_it <= done_d;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx. Expected line sequences come
// from a bit-list model of the frame format, expanded by the bit period.
module tb_uart_tx;

    logic       clk;
    logic       rst;
    logic [8:0] cfg_clk_div;
    logic       cfg_has_parity;
    logic       cfg_odd_parity;
    logic       cfg_extend_stop;
    logic       cfg_lsb_first;
    logic [1:0] cfg_word;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       uart_tx_busy;
    logic       uart_tx_done_it;
    logic       ms_utx;

    int errors = 0;
    int checks = 0;
    bit exp_bits[$];

    uart_tx #(.DIV_W(9)) dut (
        .clk             (clk),
        .rst             (rst),
        .cfg_clk_div     (cfg_clk_div),
        .cfg_has_parity  (cfg_has_parity),
        .cfg_odd_parity  (cfg_odd_parity),
        .cfg_extend_stop (cfg_extend_stop),
        .cfg_lsb_first   (cfg_lsb_first),
        .cfg_word        (cfg_word),
        .tx_data         (tx_data),
        .tx_valid        (tx_valid),
        .tx_ready        (tx_ready),
        .uart_tx_busy    (uart_tx_busy),
        .uart_tx_done_it (uart_tx_done_it),
        .ms_utx          (ms_utx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Frame as a list of line levels, one entry per bit period.
    function automatic void build_frame(input bit par, input bit odd, input bit ext,
                                        input bit lsb, input logic [1:0] word,
                                        input logic [7:0] data);
        int n;
        bit p;
        logic [7:0] d;
        d = data;
        n = 5 + int'(word);
        exp_bits = {};
        exp_bits.push_back(1'b0);
        for (int k = 0; k < n; k++) exp_bits.push_back(d[lsb ? k : n - 1 - k]);
        if (par) begin
            p = odd;
            for (int k = 0; k < n; k++) p = p ^ d[k];
            exp_bits.push_back(p);
        end
        exp_bits.push_back(1'b1);
        if (ext) exp_bits.push_back(1'b1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(output bit ok);
        int n;
        n = 0;
        while (tx_ready !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        ok = (tx_ready === 1'b1);
    endtask

    task automatic set_cfg(input int div, input bit par, input bit odd, input bit ext,
                           input bit lsb, input logic [1:0] word);
        cfg_clk_div     = 9'(div);
        cfg_has_parity  = par;
        cfg_odd_parity  = odd;
        cfg_extend_stop = ext;
        cfg_lsb_first   = lsb;
        cfg_word        = word;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tx_valid = 1'b1;
        tx_data = 8'h00;
        set_cfg(0, 0, 0, 0, 1, 2'b11);
        repeat (3) tick();
        checks++;
        if (ms_utx !== 1'b1) begin errors++; $display("FAIL reset_line: got %b expected 1", ms_utx); end
        checks++;
        if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", tx_ready); end
        checks++;
        if (uart_tx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", uart_tx_busy); end
        checks++;
        if (uart_tx_done_it !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", uart_tx_done_it); end
        tx_valid = 1'b0;
        rst = 1'b0;
        tick();
        checks++;
        if (ms_utx !== 1'b1 || uart_tx_busy !== 1'b0) begin
            errors++; $display("FAIL idle_after_reset: line=%b busy=%b expected 1/0", ms_utx, uart_tx_busy);
        end
    endtask

    // One frame; with scramble, cfg/data/valid are randomised every cycle of the frame.
    task automatic run_frame(input string name, input int div, input bit par, input bit odd,
                             input bit ext, input bit lsb, input logic [1:0] word,
                             input logic [7:0] data, input bit scramble);
        int len;
        bit ok;
        build_frame(par, odd, ext, lsb, word, data);
        len = exp_bits.size() * (div + 1);
        wait_ready(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL %s ready_timeout: tx_ready=%b expected 1", name, tx_ready); end
        set_cfg(div, par, odd, ext, lsb, word);
        tx_data = data;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        for (int i = 0; i < len; i++) begin
            checks++;
            if (ms_utx !== exp_bits[i / (div + 1)]) begin
                errors++;
                $display("FAIL %s line cycle %0d: got %b expected %b", name, i + 1, ms_utx, exp_bits[i / (div + 1)]);
            end
            checks++;
            if (uart_tx_busy !== 1'b1 || tx_ready !== 1'b0 || uart_tx_done_it !== 1'b0) begin
                errors++;
                $display("FAIL %s flags cycle %0d: busy=%b ready=%b done=%b expected 1/0/0",
                         name, i + 1, uart_tx_busy, tx_ready, uart_tx_done_it);
            end
            if (scramble) begin
                set_cfg($urandom_range(0, 7), 1'($urandom), 1'($urandom), 1'($urandom),
                        1'($urandom), 2'($urandom));
                tx_data = 8'($urandom);
                tx_valid = 1'($urandom);
            end
            tick();
        end
        tx_valid = 1'b0;
        checks++;
        if (uart_tx_done_it !== 1'b1 || tx_ready !== 1'b1 || uart_tx_busy !== 1'b0 || ms_utx !== 1'b1) begin
            errors++;
            $display("FAIL %s done_cycle %0d: done=%b ready=%b busy=%b line=%b expected 1/1/0/1",
                     name, len + 1, uart_tx_done_it, tx_ready, uart_tx_busy, ms_utx);
        end
        tick();
        checks++;
        if (uart_tx_done_it !== 1'b0 || ms_utx !== 1'b1) begin
            errors++;
            $display("FAIL %s after_done: done=%b line=%b expected 0/1", name, uart_tx_done_it, ms_utx);
        end
    endtask

    // Two frames with tx_valid held: exactly one idle-high cycle between them.
    task automatic test_back_to_back(input string name, input int div, input bit par,
                                     input bit odd, input bit ext, input bit lsb,
                                     input logic [1:0] word, input logic [7:0] d0,
                                     input logic [7:0] d1);
        bit q0[$];
        bit q1[$];
        bit ok;
        build_frame(par, odd, ext, lsb, word, d0);
        q0 = exp_bits;
        build_frame(par, odd, ext, lsb, word, d1);
        q1 = exp_bits;
        wait_ready(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL %s ready_timeout: tx_ready=%b expected 1", name, tx_ready); end
        set_cfg(div, par, odd, ext, lsb, word);
        tx_data = d0;
        tx_valid = 1'b1;
        tick();
        tx_data = d1;
        for (int i = 0; i < q0.size() * (div + 1); i++) begin
            checks++;
            if (ms_utx !== q0[i / (div + 1)] || uart_tx_done_it !== 1'b0) begin
                errors++;
                $display("FAIL %s frame0 cycle %0d: line=%b done=%b expected %b/0",
                         name, i + 1, ms_utx, uart_tx_done_it, q0[i / (div + 1)]);
            end
            tick();
        end
        checks++;
        if (ms_utx !== 1'b1 || uart_tx_done_it !== 1'b1 || tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s gap: line=%b done=%b ready=%b expected 1/1/1", name, ms_utx, uart_tx_done_it, tx_ready);
        end
        tick();
        tx_valid = 1'b0;
        for (int i = 0; i < q1.size() * (div + 1); i++) begin
            checks++;
            if (ms_utx !== q1[i / (div + 1)] || uart_tx_done_it !== 1'b0) begin
                errors++;
                $display("FAIL %s frame1 cycle %0d: line=%b done=%b expected %b/0",
                         name, i + 1, ms_utx, uart_tx_done_it, q1[i / (div + 1)]);
            end
            tick();
        end
        checks++;
        if (uart_tx_done_it !== 1'b1 || ms_utx !== 1'b1) begin
            errors++; $display("FAIL %s done1: done=%b line=%b expected 1/1", name, uart_tx_done_it, ms_utx);
        end
        tick();
    endtask

    task automatic test_reset_midframe();
        set_cfg(4, 0, 0, 0, 1, 2'b11);
        tx_data = 8'hCA;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        repeat (12) tick();
        checks++;
        if (uart_tx_busy !== 1'b1) begin errors++; $display("FAIL rst_mid_busy: got %b expected 1", uart_tx_busy); end
        rst = 1'b1;
        tx_valid = 1'b1;
        tick();
        checks++;
        if (ms_utx !== 1'b1 || tx_ready !== 1'b1 || uart_tx_busy !== 1'b0 || uart_tx_done_it !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_abort: line=%b ready=%b busy=%b done=%b expected 1/1/0/0",
                     ms_utx, tx_ready, uart_tx_busy, uart_tx_done_it);
        end
        tick();
        checks++;
        if (ms_utx !== 1'b1 || uart_tx_busy !== 1'b0) begin
            errors++; $display("FAIL rst_no_accept: line=%b busy=%b expected 1/0", ms_utx, uart_tx_busy);
        end
        rst = 1'b0;
        tx_valid = 1'b0;
        for (int i = 0; i < 60; i++) begin
            checks++;
            if (uart_tx_done_it !== 1'b0 || ms_utx !== 1'b1) begin
                errors++;
                $display("FAIL rst_quiet cycle %0d: done=%b line=%b expected 0/1", i, uart_tx_done_it, ms_utx);
            end
            tick();
        end
        run_frame("rst_next", 4, 0, 0, 0, 1, 2'b11, 8'hCA, 1'b0);
    endtask

    task automatic test_midframe_cfg();
        run_frame("cfg_toggle_cur", 2, 1, 0, 0, 1, 2'b11, 8'hB5, 1'b1);
        run_frame("cfg_toggle_next", 2, 1, 0, 0, 0, 2'b01, 8'hB5, 1'b0);
    endtask

    task automatic test_random();
        for (int t = 0; t < 24; t++) begin
            run_frame("random", $urandom_range(0, 3), 1'($urandom), 1'($urandom), 1'($urandom),
                      1'($urandom), 2'($urandom), 8'($urandom), ($urandom_range(0, 2) == 0));
        end
        for (int t = 0; t < 4; t++) begin
            test_back_to_back("b2b_random", $urandom_range(0, 2), 1'($urandom), 1'($urandom),
                              1'($urandom), 1'($urandom), 2'($urandom), 8'($urandom), 8'($urandom));
        end
    endtask

    initial begin
        test_reset();
        run_frame("8N1_lsb_CA", 4, 0, 0, 0, 1, 2'b11, 8'hCA, 1'b0);
        run_frame("8E1_msb_53", 4, 1, 0, 0, 0, 2'b11, 8'h53, 1'b0);
        run_frame("7O1_msb_41", 1, 1, 1, 0, 0, 2'b10, 8'h41, 1'b0);
        test_back_to_back("b2b_5N2", 0, 0, 0, 1, 1, 2'b00, 8'hF8, 8'h80);
        test_reset_midframe();
        test_midframe_cfg();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
